pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined CPU. It replaces the ad-hoc hazard signals with a single controller that arbitrates three events:
- load-use hazard, detected in ID;
- taken branch, resolved in ID;
- multi-cycle data-memory access, waited on in MEM.

It drives the PC and pipeline-register enables, bubble and flush controls, and exports stall/flush performance counters for the bench.

Parameters:
CNT_W, 32, width of stall/flush/wait counters
TIMEOUT, 16, max consecutive cycles in MEM_WAIT before fault

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  CPU run enable
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
ex_memread_i  in  1  ID/EX MemRead
ex_rd_i  in  5  ID/EX rd
branch_taken_i  in  1  branch in ID resolved taken
dmem_req_i  in  1  MEM stage issues load/store
dmem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear to NOP
idex_bubble_o  out  1  zero ID/EX control bits
pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
fault_o  out  1  sticky memory-timeout fault
stall_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  flush cycles

Behaviour:
- States: IDLE, RUN, MEM_WAIT, FAULT. The state register is the only sequential control; hazard outputs are combinational from state and inputs, so they take effect in the same cycle.
- Reset (rst_i=1 at posedge):
  - state=IDLE, fault_o=0, both counters=0, wait counter=0.
  - Applies from any state, including mid-MEM_WAIT.
- IDLE:
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, pipe_hold_o=0.
  - start_i=1 -> RUN on next edge.
- RUN, priority order highest first:
  1. Memory wait (dmem_req_i=1 and dmem_ack_i=0):
     - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0, ifid_flush_o=0.
     - next=MEM_WAIT, wait counter=1.
  2. Load-use (ex_memread_i=1, ex_rd_i!=0, ex_rd_i equal to id_rs1_i or id_rs2_i):
     - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
     - stall_cnt_o+1.
     - A simultaneous branch_taken_i is ignored this cycle (its operands are not yet valid); no flush is asserted or counted.
  3. branch_taken_i=1:
     - ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
     - flush_cnt_o+1.
  4. Otherwise: pc_write_o=1, ifid_write_o=1, all other controls 0.
  - start_i=0 in RUN -> IDLE next edge; the current cycle still follows the rules above.
- MEM_WAIT:
  - Full freeze: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, no bubble, no flush, counters unchanged.
  - dmem_ack_i=1 -> RUN. The ack cycle releases the freeze: outputs evaluate with RUN rules 2–4 (rule 1 is skipped), so the pipeline advances on that edge.
  - Otherwise the wait counter increments; reaching TIMEOUT -> FAULT.
- FAULT:
  - Full freeze as in MEM_WAIT, fault_o=1.
  - Exits only via rst_i.
- Counters:
  - Unsigned, saturating at all-ones (no wrap).
  - Registered: the value is visible the cycle after the event.
- rd=x0 never creates a load-use hazard.
- ifid_flush_o and ifid_write_o are never both 0 while pc_write_o=1.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum (IDLE, RUN, MEM_WAIT, FAULT);
  - REG_ADDR_W=5;
  - localparam X0=5'd0.
- One sub-module, sat_counter (parameter CNT_W; inputs clk_i, rst_i, inc_i; output cnt_o), is instantiated twice for the stall and flush counters.
- The wait counter is inline.

Test Plan:
1. Reset, then start_i=1 with no hazards for 5 cycles -> pc_write_o=1 every RUN cycle; stall_cnt_o=0, flush_cnt_o=0.
2. ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle -> pc_write_o=0, idex_bubble_o=1 that cycle; stall_cnt_o=1 next cycle. Repeat with ex_rd_i=0 -> no stall.
3. Load-use and branch_taken_i=1 in the same cycle -> stall only, ifid_flush_o=0, flush_cnt_o unchanged. Next cycle branch_taken_i=1 alone -> ifid_flush_o=1, flush_cnt_o=1.
4. dmem_req_i=1 with ack withheld 3 cycles, then ack -> pipe_hold_o=1 for 4 cycles (entry + 3), released on the ack cycle; state RUN after.
5. dmem_req_i=1, no ack for 16 cycles (TIMEOUT=16) -> fault_o=1 and sticky. Assert rst_i -> fault_o=0, state IDLE, counters 0.
6. Preload stall_cnt_o to all-ones (CNT_W=4 build) and force one more stall -> stays 15. Assert rst_i during MEM_WAIT -> IDLE next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared hazard-controller types and register-address constants
package cpu_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, FAULT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: unsigned event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) r_cnt <= '0;
    else if (inc_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign cnt_o = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: arbitrates load-use, taken-branch and memory-wait hazards
// into PC / IF-ID / ID-EX controls, with a memory-timeout fault and perf counters.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  pipe_hold_o,
  output logic                  fault_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_mem_stall, w_adv, w_load_use, w_timeout;
  assign w_mem_stall = r_state == RUN && dmem_req_i && !dmem_ack_i;
  // the ack cycle of a memory wait behaves like RUN minus the memory-wait rule
  assign w_adv      = (r_state == RUN && !w_mem_stall) || (r_state == MEM_WAIT && dmem_ack_i);
  assign w_load_use = ex_memread_i && ex_rd_i != X0 && (ex_rd_i == id_rs1_i || ex_rd_i == id_rs2_i);
  assign w_timeout  = r_wait == WAIT_W'(TIMEOUT - 1);
  always_ff @(posedge clk_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i)
    if (rst_i) r_wait <= '0;
    else if (w_mem_stall) r_wait <= WAIT_W'(1);
    else if (r_state == MEM_WAIT && !dmem_ack_i) r_wait <= r_wait + 1'b1;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = start_i ? RUN : IDLE;
      RUN:      w_next = w_mem_stall ? MEM_WAIT : start_i ? RUN : IDLE;
      MEM_WAIT: w_next = dmem_ack_i ? RUN : w_timeout ? FAULT : MEM_WAIT;
      FAULT:    w_next = FAULT;
    endcase
  end
  always_comb begin
    pc_write_o    = w_adv && !w_load_use;
    ifid_write_o  = w_adv && !w_load_use;
    ifid_flush_o  = w_adv && !w_load_use && branch_taken_i;
    idex_bubble_o = r_state == IDLE || (w_adv && w_load_use);
    pipe_hold_o   = w_mem_stall || (r_state == MEM_WAIT && !dmem_ack_i) || r_state == FAULT;
    fault_o       = r_state == FAULT;
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_adv && w_load_use), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(ifid_flush_o), .cnt_o(flush_cnt_o)
  );
endmodule
